// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Multiplies take 5 cycles and divides take 10. Operands are captured when an operation issues.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_q, b_q;
    logic        sgn_q;

    logic signed [63:0] sa, sb, dvs, prod;
    logic [31:0]        quot, rem;

    // Signed ops sign-extend and unsigned ops zero-extend, so one signed
    // 64-bit datapath serves both. The divisor is forced nonzero so that
    // divide-by-zero never evaluates; that result is discarded anyway.
    always_comb begin
        sa   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        sb   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        dvs  = (b_q == 32'b0) ? 64'sd1 : sb;
        prod = sa * sb;
        quot = 32'(sa / dvs);
        rem  = 32'(sa % dvs);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Busy  <= 1'b0;
            HI    <= 32'b0;
            LO    <= 32'b0;
            a_q   <= 32'b0;
            b_q   <= 32'b0;
            sgn_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (En) begin
                        case (MDUOp)
                            4'd1, 4'd2: begin
                                state <= MUL;
                                cnt   <= 4'd4;
                                Busy  <= 1'b1;
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= (MDUOp == 4'd1);
                            end
                            4'd3, 4'd4: begin
                                state <= DIV;
                                cnt   <= 4'd9;
                                Busy  <= 1'b1;
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= (MDUOp == 4'd3);
                            end
                            4'd5:    HI <= A;
                            4'd6:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt == 4'd0) begin
                        {HI, LO} <= prod;
                        state    <= IDLE;
                        Busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DIV: begin
                    if (cnt == 4'd0) begin
                        if (b_q != 32'b0) begin
                            LO <= quot;
                            HI <= rem;
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'b0, m_lo = 32'b0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .En(En), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic exp_busy);
        chk({tag, ".busy"}, {31'b0, Busy}, {31'b0, exp_busy});
        chk({tag, ".hi"}, HI, m_hi);
        chk({tag, ".lo"}, LO, m_lo);
    endtask

    // Reference results come straight from the arithmetic definitions.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              si, sj;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = sp;
            end
            4'd2: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                {m_hi, m_lo} = up;
            end
            4'd3: if (b != 0) begin
                si = a;
                sj = b;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else begin
                    m_lo = si / sj;
                    m_hi = si % sj;
                end
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op; when junk is set, throw random ops at the busy unit (all must be ignored).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit junk);
        int lat;
        En = 1'b1; MDUOp = op; A = a; B = b;
        step();
        En = 1'b0; MDUOp = 4'd0;
        if (op == 4'd5 || op == 4'd6) begin
            ref_op(op, a, b);
            chk_state("mtx", 1'b0);
            return;
        end
        lat = (op <= 4'd2) ? 5 : 10;
        for (int i = 0; i < lat; i++) begin
            chk_state("busy", 1'b1);
            En    = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            MDUOp = junk ? 4'($urandom_range(0, 15)) : 4'd0;
            A = $urandom; B = $urandom;
            step();
        end
        ref_op(op, a, b);
        chk_state("done", 1'b0);
        En = 1'b0; MDUOp = 4'd0;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; En = 1'b0; MDUOp = 4'd0; A = 32'b0; B = 32'b0;
        step();
        En = 1'b1; MDUOp = 4'd5; A = 32'hDEAD_BEEF;
        step();
        chk_state("reset", 1'b0);
        En = 1'b0; MDUOp = 4'd0;

        reset = 1'b0;
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult.hi", HI, 32'hFFFF_FFFF);
        chk("mult.lo", LO, 32'hFFFF_FFFA);
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu.hi", HI, 32'hFFFF_FFFE);
        chk("multu.lo", LO, 32'h0000_0001);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div.lo", LO, 32'hFFFF_FFFD);
        chk("div.hi", HI, 32'hFFFF_FFFF);
        do_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("divu.lo", LO, 32'h7FFF_FFFC);
        chk("divu.hi", HI, 32'h0000_0001);

        do_op(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        En = 1'b1; MDUOp = 4'd3; A = 32'd99; B = 32'd0;
        step();
        En = 1'b1; MDUOp = 4'd6; A = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) begin
            chk_state("div0", 1'b1);
            step();
        end
        En = 1'b0; MDUOp = 4'd0;
        chk_state("div0.done", 1'b0);
        chk("div0.hi", HI, 32'h1234_5678);

        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf.lo", LO, 32'h8000_0000);
        chk("ovf.hi", HI, 32'h0000_0000);

        En = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        step();
        En = 1'b0; MDUOp = 4'd0;
        repeat (3) step();
        chk({31'b0, Busy}, 32'd1, 32'd1) ;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'b0; m_lo = 32'b0;
        chk_state("midrst", 1'b0);
        repeat (12) step();
        chk_state("midrst.later", 1'b0);

        En = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'hFFFF_FFFD;
        step();
        for (int i = 0; i < 5; i++) begin
            chk({31'b0, Busy}, 32'd1, 32'd1);
            step();
        end
        ref_op(4'd1, 32'd7, 32'hFFFF_FFFD);
        chk_state("b2b.first", 1'b0);
        step();
        En = 1'b0; MDUOp = 4'd0;
        chk_state("b2b.reissue", 1'b1);
        repeat (5) step();
        chk_state("b2b.second", 1'b0);

        En = 1'b0; MDUOp = 4'd1; A = 32'd5; B = 32'd5;
        repeat (3) step();
        chk_state("en0", 1'b0);
        MDUOp = 4'd0;

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (n % 13 == 5) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (n % 7 == 3) rb = rb >> $urandom_range(20, 31);
            do_op(rop, ra, rb, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
